// File: rtl/amci_pkg.sv
// amci_pkg: AMCI MOSI/MISO field layout, command op-codes and sequencer states
package amci_pkg;
  localparam int MOSI_W = 98;
  localparam int MISO_W = 38;
  localparam int MOSI_WADDR = 0;
  localparam int MOSI_WDATA = 32;
  localparam int MOSI_RADDR = 64;
  localparam int MOSI_WRITE = 96;
  localparam int MOSI_READ = 97;
  localparam int MISO_RDATA = 0;
  localparam int MISO_WIDLE = 32;
  localparam int MISO_RIDLE = 33;
  localparam int MISO_WRESP = 34;
  localparam int MISO_RRESP = 36;
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_RMW = 2'd2;
  localparam logic [1:0] OP_POLL = 2'd3;
  typedef enum logic [2:0] {IDLE, RD_GO, RD_WAIT, WR_GO, WR_WAIT, GAP, RSP} state_t;
endpackage

// File: rtl/amci_pack.sv
// amci_pack: pure pack of AMCI MOSI fields and unpack of MISO fields
module amci_pack import amci_pkg::*; (
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       raddr,
  input  logic              write,
  input  logic              read,
  output logic [MOSI_W-1:0] mosi,
  input  logic [MISO_W-1:0] miso,
  output logic [31:0]       rdata,
  output logic              widle,
  output logic              ridle,
  output logic [1:0]        wresp,
  output logic [1:0]        rresp
);
  assign mosi = {read, write, raddr, wdata, waddr};
  assign rdata = miso[MISO_RDATA +: 32];
  assign widle = miso[MISO_WIDLE];
  assign ridle = miso[MISO_RIDLE];
  assign wresp = miso[MISO_WRESP +: 2];
  assign rresp = miso[MISO_RRESP +: 2];
endmodule

// File: rtl/amci_rmw_sequencer.sv
// amci_rmw_sequencer: sequences WRITE/READ/RMW/POLL commands into AMCI write/read pulses
module amci_rmw_sequencer import amci_pkg::*; #(
  parameter int POLL_TIMEOUT = 1000000,
  parameter int POLL_GAP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [31:0]       CMD_ADDR,
  input  logic [31:0]       CMD_DATA,
  input  logic [31:0]       CMD_MASK,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_DATA,
  output logic [1:0]        RSP_RESP,
  output logic              RSP_TIMEOUT,
  output logic [MOSI_W-1:0] AMCI_MOSI,
  input  logic [MISO_W-1:0] AMCI_MISO
);
  localparam int CW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = POLL_GAP > 0 ? $clog2(POLL_GAP + 1) : 1;
  state_t state, state_n;
  logic [1:0] op;
  logic [31:0] addr, data, mask, waddr, wdata, raddr, rdata;
  logic write, read, first, widle, ridle;
  logic [1:0] wresp, rresp;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic accept, rd_go, wr_go, rd_done, wr_done, match, tmo;
  amci_pack u_pack (
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .write(write), .read(read), .mosi(AMCI_MOSI),
    .miso(AMCI_MISO), .rdata(rdata), .widle(widle), .ridle(ridle), .wresp(wresp), .rresp(rresp)
  );
  always_comb begin
    accept = state == IDLE && CMD_VALID && CMD_READY;
    rd_go = state == RD_GO && ridle;
    wr_go = state == WR_GO && widle;
    rd_done = state == RD_WAIT && !first && ridle;
    wr_done = state == WR_WAIT && !first && widle;
    match = ((rdata ^ data) & mask) == '0;
    tmo = cnt == CW'(POLL_TIMEOUT);
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = CMD_OP == OP_WRITE ? WR_GO : RD_GO;
      RD_GO: if (rd_go) state_n = RD_WAIT;
      RD_WAIT: if (rd_done) state_n = op == OP_READ || rresp != 2'd0 ? RSP :
                                      op == OP_RMW ? WR_GO :
                                      match || tmo ? RSP :
                                      POLL_GAP == 0 ? RD_GO : GAP;
      WR_GO: if (wr_go) state_n = WR_WAIT;
      WR_WAIT: if (wr_done) state_n = RSP;
      GAP: if (gcnt == GW'(1)) state_n = RD_GO;
      RSP: if (RSP_READY) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_DATA <= '0;
      RSP_RESP <= '0;
      RSP_TIMEOUT <= 1'b0;
      {op, addr, data, mask, waddr, wdata, raddr} <= '0;
      {write, read, first} <= '0;
      cnt <= '0;
      gcnt <= '0;
    end else begin
      state <= state_n;
      CMD_READY <= state_n == IDLE;
      RSP_VALID <= state_n == RSP;
      read <= rd_go;
      write <= wr_go;
      first <= rd_go || wr_go;
      cnt <= state == IDLE ? '0 : state != RSP && !tmo ? cnt + 1'b1 : cnt;
      gcnt <= state == GAP ? gcnt - 1'b1 : GW'(POLL_GAP);
      if (accept) begin
        {op, addr, data, mask} <= {CMD_OP, CMD_ADDR, CMD_DATA, CMD_MASK};
        RSP_DATA <= '0;
        RSP_RESP <= '0;
        RSP_TIMEOUT <= 1'b0;
      end
      if (rd_go) raddr <= addr;
      if (wr_go) begin
        waddr <= addr;
        wdata <= op == OP_RMW ? (RSP_DATA & ~mask) | (data & mask) : data;
      end
      if (rd_done) begin
        RSP_DATA <= rdata;
        if (rresp != 2'd0) RSP_RESP <= rresp;
        RSP_TIMEOUT <= op == OP_POLL && rresp == 2'd0 && !match && tmo;
      end
      if (wr_done && wresp != 2'd0) RSP_RESP <= wresp;
    end
  end
endmodule
